// File: rtl/acq_readout.sv
// acq_readout: drains NSAMPLE words from the acquisition RAM onto a valid/ready stream.
// Define READOUT_CHECKSUM_EN to append a modulo-2^DATAWIDTH sum word after the samples.
module acq_readout #(
  parameter int NSAMPLE   = 10,
  parameter int ADDRSIZE  = 7,
  parameter int DATAWIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_rd_en,
  output logic [ADDRSIZE-1:0]  ram_addr,
  input  logic [DATAWIDTH-1:0] ram_data,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  // state | meaning
  // IDLE  | waiting for start, address parked at 0
  // READ  | issuing RAM reads for addresses 0..NSAMPLE-1
  // DRAIN | all reads issued, waiting for the final word to transfer
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDRSIZE-1:0] LAST_ADDR = ADDRSIZE'(NSAMPLE - 1);

  state_t               state;
  logic [DATAWIDTH-1:0] skid_data;
  logic                 skid_valid;
  logic                 skid_fin;
  logic                 out_fin;
  logic                 rd_pend;
  logic                 pend_fin;
  logic                 xfer;
  logic [1:0]           occ;

  assign xfer = out_valid & out_ready;
  // Words held or in flight once this cycle's transfer leaves; counting the
  // departing word keeps one word per cycle flowing with out_ready high.
  assign occ = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(xfer);
  assign ram_rd_en = (state == READ) && (occ < 2'd2);

`ifdef READOUT_CHECKSUM_EN
  logic [DATAWIDTH-1:0] sum;
`else
  assign out_last = out_fin;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ram_addr   <= '0;
      rd_pend    <= 1'b0;
      pend_fin   <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      skid_fin   <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_fin    <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
      sum        <= '0;
      out_last   <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      rd_pend  <= ram_rd_en;
      pend_fin <= ram_rd_en && (ram_addr == LAST_ADDR);

      case (state)
        IDLE: begin
          if (start) begin
            state    <= READ;
            busy     <= 1'b1;
            ram_addr <= '0;
`ifdef READOUT_CHECKSUM_EN
            sum      <= '0;
`endif
          end
        end
        READ: begin
          if (ram_rd_en) begin
            if (ram_addr == LAST_ADDR) state <= DRAIN;
            else ram_addr <= ram_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (xfer && out_last) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            ram_addr <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      // Output register refills from the skid entry first so order is kept.
      if (!out_valid || xfer) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          out_valid  <= 1'b1;
          out_fin    <= skid_fin;
          skid_valid <= rd_pend;
          skid_data  <= ram_data;
          skid_fin   <= pend_fin;
        end else if (rd_pend) begin
          out_data  <= ram_data;
          out_valid <= 1'b1;
          out_fin   <= pend_fin;
        end else begin
          out_valid <= 1'b0;
          out_fin   <= 1'b0;
        end
      end else if (rd_pend) begin
        skid_data  <= ram_data;
        skid_valid <= 1'b1;
        skid_fin   <= pend_fin;
      end

`ifdef READOUT_CHECKSUM_EN
      // Nothing is buffered behind the final sample, so the sum word takes its slot.
      if (xfer) begin
        out_last <= out_fin;
        if (!out_last) sum <= sum + out_data;
        if (out_fin) begin
          out_data  <= sum + out_data;
          out_valid <= 1'b1;
          out_fin   <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_acq_readout.sv
// Bench for acq_readout: directed latency/ordering cases plus random stimulus,
// checked every cycle against a transaction-level scoreboard of expected words.
`timescale 1ns/1ps
module tb_acq_readout;
  localparam int NSAMPLE   = 10;
  localparam int ADDRSIZE  = 7;
  localparam int DATAWIDTH = 12;
`ifdef READOUT_CHECKSUM_EN
  localparam int NWORDS    = NSAMPLE + 1;
  localparam int LAST_WORD = 'hA2D;
`else
  localparam int NWORDS    = NSAMPLE;
  localparam int LAST_WORD = 'h109;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b1;
  logic busy, done, ram_rd_en, out_valid, out_last;
  logic [ADDRSIZE-1:0]  ram_addr;
  logic [DATAWIDTH-1:0] ram_data = '0;
  logic [DATAWIDTH-1:0] out_data;

  acq_readout #(.NSAMPLE(NSAMPLE), .ADDRSIZE(ADDRSIZE), .DATAWIDTH(DATAWIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_data(ram_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM; off-cycles return noise so late/early capture shows up.
  logic [DATAWIDTH-1:0] mem [0:(1<<ADDRSIZE)-1];
  always @(posedge clk) ram_data <= ram_rd_en ? mem[ram_addr] : DATAWIDTH'($urandom);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard state
  logic [DATAWIDTH-1:0] q[$];
  logic [DATAWIDTH-1:0] c_exp, prev_data, first_word, last_word;
`ifdef READOUT_CHECKSUM_EN
  logic [DATAWIDTH-1:0] csum;
`endif
  bit m_busy = 0, m_done = 0, prev_reset = 0, prev_valid = 0, prev_ready = 0, prev_last = 0;
  bit c_xfer, c_last, got_rd, got_valid;
  int m_rd = 0, m_words = 0, smp;
  int done_cnt = 0, t_start = 0, t_rd = 0, t_valid = 0, t_last = 0, t_done = 0, busy_cycles = 0;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_busy = 0;
      m_done = 0;
      prev_reset = 1;
      prev_valid = 0;
    end else begin
      if (prev_reset) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        prev_reset = 0;
      end
      c_xfer = out_valid && out_ready;
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (done) begin done_cnt++; t_done = cyc; end
      if (busy) busy_cycles++;
      if (!m_busy) begin
        chk("idle_rd_en", ram_rd_en, 0);
        chk("idle_addr", ram_addr, 0);
        chk("idle_valid", out_valid, 0);
      end
      chk("addr_range", ram_addr <= NSAMPLE - 1, 1);
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (ram_rd_en) begin
        chk("rd_addr", ram_addr, m_rd);
        m_rd++;
        if (!got_rd) begin got_rd = 1; t_rd = cyc; end
      end
      if (out_valid && !got_valid) begin got_valid = 1; t_valid = cyc; end
      c_last = 0;
      if (c_xfer) begin
        if (q.size() == 0) chk("spurious_word", 1, 0);
        else begin
          c_exp = q.pop_front();
          chk("word", out_data, c_exp);
          c_last = (q.size() == 0);
          chk("last_flag", out_last, c_last);
          if (m_words == 0) first_word = out_data;
          if (out_last) begin last_word = out_data; t_last = cyc; end
          m_words++;
        end
      end else if (out_valid) begin
        chk("last_only_final", out_last, q.size() == 1);
      end
      if (ram_rd_en || c_xfer) begin
        smp = (m_words < NSAMPLE) ? m_words : NSAMPLE;
        chk("occupancy", (m_rd - smp) <= 2, 1);
      end
      m_done = c_last;
      if (m_busy) m_busy = !c_last;
      else if (start) begin
        m_busy = 1; m_rd = 0; m_words = 0; got_rd = 0; got_valid = 0;
        t_start = cyc; busy_cycles = 0;
`ifdef READOUT_CHECKSUM_EN
        csum = '0;
`endif
        for (int k = 0; k < NSAMPLE; k++) begin
          q.push_back(mem[k]);
`ifdef READOUT_CHECKSUM_EN
          csum = csum + mem[k];
`endif
        end
`ifdef READOUT_CHECKSUM_EN
        q.push_back(csum);
`endif
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Stimulus
  int mode = 0;
  int pat_i = 0;
  logic [3:0] pat = 4'b1001;

  task automatic step();
    @(posedge clk);
    #1;
    case (mode)
      0: out_ready = 1'b1;
      1: begin out_ready = pat[pat_i % 4]; pat_i++; end
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic wait_done(input int budget);
    int base, n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin step(); n++; end
    chk("done_reached", done_cnt > base, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int d;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < (1 << ADDRSIZE); k++) mem[k] = DATAWIDTH'('h100 + k);
    repeat (3) step();
    reset = 1'b0;
    step();

    // Free-flowing readout: latency and ordering pinned to literals
    pulse_start();
    wait_done(60);
    chk("t1_first_rd", t_rd - t_start, 1);
    chk("t1_first_valid", t_valid - t_start, 3);
    chk("t1_last_xfer", t_last - t_start, NWORDS + 2);
    chk("t1_done", t_done - t_start, NWORDS + 3);
    chk("t1_busy_cycles", busy_cycles, NWORDS + 2);
    chk("t1_words", m_words, NWORDS);
    chk("t1_first_word", first_word, 'h100);
    chk("t1_last_word", last_word, LAST_WORD);

    // Backpressure pattern 1,0,0,1
    mode = 1; pat_i = 0;
    pulse_start();
    wait_done(120);
    mode = 0;
    chk("t2_words", m_words, NWORDS);
    chk("t2_first_word", first_word, 'h100);
    chk("t2_last_word", last_word, LAST_WORD);

    // Second start while busy is ignored
    d = done_cnt;
    pulse_start();
    repeat (4) step();
    pulse_start();
    wait_done(60);
    repeat (20) step();
    chk("t3_single_done", done_cnt - d, 1);
    chk("t3_words", m_words, NWORDS);

    // Reset in the cycle the 4th word transfers
    d = done_cnt;
    pulse_start();
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (20) step();
    chk("t4_no_done", done_cnt - d, 0);
    chk("t4_words_before_reset", m_words, 3);
    pulse_start();
    wait_done(60);
    chk("t4_restart_first_word", first_word, 'h100);
    chk("t4_restart_words", m_words, NWORDS);

    // start held high: back-to-back readouts
    start = 1'b1;
    wait_done(60);
    d = t_done;
    repeat (3) step();
    chk("t5_accept_in_done_cycle", t_start, d);
    chk("t5_rd_after_done", t_rd, d + 1);
    wait_done(60);
    start = 1'b0;
    wait_done(60);

`ifdef READOUT_CHECKSUM_EN
    for (int k = 0; k < (1 << ADDRSIZE); k++) mem[k] = 'hFFF;
    pulse_start();
    wait_done(60);
    chk("t6_csum_word", last_word, 'hFF6);
    chk("t6_csum_words", m_words, 11);
    chk("t6_csum_done", t_done - t_start, 14);
`endif

    // Random traffic, backpressure, start and occasional reset
    for (int k = 0; k < (1 << ADDRSIZE); k++) mem[k] = DATAWIDTH'($urandom);
    mode = 2;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    start = 1'b0;
    reset = 1'b0;
    mode = 0;
    for (int i = 0; i < 100 && (m_busy || prev_reset); i++) step();
    chk("final_idle", m_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
